cache_read_arbiter: RTL

CACHE_READ_ARBITER -- requirements
Module: cache_read_arbiter

---
 rtl/cache_read_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/cache_read_arbiter.sv
// Two-requester (icache/dcache) read arbiter in front of a single burst memory port.
// One burst outstanding at a time; ties resolved round-robin against the last winner.
module cache_read_arbiter (
   input  logic        clk,
   input  logic        rst,

   input  logic [31:0] rq0_araddr,
   input  logic [3:0]  rq0_arlen,
   input  logic        rq0_arvalid,
   output logic        rq0_arready,
   output logic [31:0] rq0_rdata,
   output logic        rq0_rvalid,
   output logic        rq0_rlast,
   input  logic        rq0_rready,

   input  logic [31:0] rq1_araddr,
   input  logic [3:0]  rq1_arlen,
   input  logic        rq1_arvalid,
   output logic        rq1_arready,
   output logic [31:0] rq1_rdata,
   output logic        rq1_rvalid,
   output logic        rq1_rlast,
   input  logic        rq1_rready,

   output logic [31:0] m_araddr,
   output logic [3:0]  m_arlen,
   output logic        m_arvalid,
   input  logic        m_arready,
   input  logic [31:0] m_rdata,
   input  logic        m_rvalid,
   input  logic        m_rlast,
   output logic        m_rready,

   output logic        busy,
   output logic        len_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t      r_state, w_state_next;
   logic        r_grant, w_grant_next;
   logic        r_last_grant, w_last_grant_next;
   logic [31:0] r_addr, w_addr_next;
   logic [3:0]  r_len, w_len_next;
   logic [3:0]  r_beat, w_beat_next;
   logic        r_len_err, w_len_err_next;

   logic [1:0][31:0] w_araddr;
   logic [1:0][3:0]  w_arlen;
   logic [1:0]       w_arvalid;
   logic [1:0]       w_rready;
   logic [1:0]       w_arready;
   logic [1:0]       w_rvalid;
   logic [1:0]       w_rlast;
   logic             w_sel;
   logic             w_m_arvalid;
   logic             w_m_rready;

   assign w_araddr  = {rq1_araddr, rq0_araddr};
   assign w_arlen   = {rq1_arlen, rq0_arlen};
   assign w_arvalid = {rq1_arvalid, rq0_arvalid};
   assign w_rready  = {rq1_rready, rq0_rready};

   // A lone requester always wins; on a tie the one not served last goes first.
   assign w_sel = (&w_arvalid) ? ~r_last_grant : w_arvalid[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_addr       <= 32'd0;
         r_len        <= 4'd0;
         r_beat       <= 4'd0;
         r_len_err    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_grant      <= w_grant_next;
         r_last_grant <= w_last_grant_next;
         r_addr       <= w_addr_next;
         r_len        <= w_len_next;
         r_beat       <= w_beat_next;
         r_len_err    <= w_len_err_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_grant_next      = r_grant;
      w_last_grant_next = r_last_grant;
      w_addr_next       = r_addr;
      w_len_next        = r_len;
      w_beat_next       = r_beat;
      w_len_err_next    = 1'b0;
      w_m_arvalid       = 1'b0;
      w_m_rready        = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (|w_arvalid) begin
               w_grant_next = w_sel;
               w_addr_next  = w_araddr[w_sel];
               w_len_next   = w_arlen[w_sel];
               w_state_next = ADDR;
            end
         end
         ADDR: begin
            w_m_arvalid = 1'b1;
            if (m_arready) begin
               w_beat_next  = 4'd0;
               w_state_next = DATA;
            end
         end
         DATA: begin
            w_m_rready = w_rready[r_grant];
            if (m_rvalid && w_m_rready) begin
               w_beat_next = r_beat + 4'd1;
               // Burst length is set by the memory's rlast; a disagreement is only flagged.
               if (m_rlast) begin
                  w_len_err_next    = (r_beat != r_len);
                  w_last_grant_next = r_grant;
                  w_state_next      = IDLE;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         logic w_is_grant;
         assign w_is_grant    = (r_grant == 1'(gi));
         assign w_arready[gi] = (r_state == ADDR) && m_arready && w_is_grant;
         assign w_rvalid[gi]  = (r_state == DATA) && m_rvalid && w_is_grant;
         assign w_rlast[gi]   = (r_state == DATA) && m_rlast && w_is_grant;
      end
   endgenerate

   assign rq0_arready = w_arready[0];
   assign rq1_arready = w_arready[1];
   assign rq0_rvalid  = w_rvalid[0];
   assign rq1_rvalid  = w_rvalid[1];
   assign rq0_rlast   = w_rlast[0];
   assign rq1_rlast   = w_rlast[1];
   assign rq0_rdata   = m_rdata;
   assign rq1_rdata   = m_rdata;

   assign m_arvalid = w_m_arvalid;
   assign m_araddr  = w_m_arvalid ? r_addr : 32'd0;
   assign m_arlen   = w_m_arvalid ? r_len : 4'd0;
   assign m_rready  = w_m_rready;

   assign busy    = (r_state != IDLE);
   assign len_err = r_len_err;

endmodule
